load_store_unit: RTL
====================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter ADDR_WIDTH, default 31, MSB index of all address buses.
REQ-002 Parameter DATA_WIDTH, default 31, MSB index of all data buses; only 31 is supported.
REQ-003 clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 rst  in  1  asynchronous, active-low reset.
REQ-005 clk_en  in  1  global advance enable; when 0 all state and outputs hold.
REQ-006 i_valid  in  1  core presents a memory operation.
REQ-007 o_ready  out  1  unit can accept an operation this cycle.
REQ-008 i_store  in  1  1 = store, 0 = load.
REQ-009 i_funct3  in  3  RV32I width/sign code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-010 i_addr  in  ADDR_WIDTH+1  byte address.
REQ-011 i_wdata  in  DATA_WIDTH+1  store data, right-aligned.
REQ-012 o_done  out  1  one-cycle pulse: operation retired (load data or store written).
REQ-013 o_rdata  out  DATA_WIDTH+1  extended load result, valid while o_done is 1 for a load.
REQ-014 o_error  out  1  one-cycle pulse: operation rejected (misaligned or illegal funct3).
REQ-015 o_read_req / o_read_addr  out  1 / ADDR_WIDTH+1  RAM data-port read request and word address.
REQ-016 i_read_data  in  DATA_WIDTH+1  RAM read word, valid the cycle after o_read_req.
REQ-017 o_write_enable / o_byte_enable / o_write_addr / o_write_data  out  1 / 4 / ADDR_WIDTH+1 / DATA_WIDTH+1  RAM write port.

Function
REQ-018 FSM states: IDLE, STORE, LOAD_REQ, LOAD_DATA, ERR; no transitions when clk_en=0.
REQ-019 o_ready SHALL be 1 only in IDLE; an operation is accepted on a rising edge with i_valid & o_ready & clk_en.
REQ-020 Accept captures i_store, i_funct3, i_addr, i_wdata into internal registers; inputs are ignored thereafter until IDLE.
REQ-021 RAM word address SHALL be {2'b00, addr[ADDR_WIDTH:2]}, driven on o_read_addr and o_write_addr.
REQ-022 Misaligned: H/HU/SH with addr[0]=1; W/SW with addr[1:0]!=0; illegal: funct3 011/110/111, or store with funct3[2]=1.
REQ-023 Misaligned or illegal accept -> ERR for one cycle (o_error=1, no RAM strobe) -> IDLE.
REQ-024 Legal store: IDLE -> STORE (o_write_enable=1 one cycle, o_done=1 same cycle) -> IDLE; latency 1 cycle.
REQ-025 Store byte enables: B = 0001<<addr[1:0]; H = 0011<<addr[1:0]; W = 1111.
REQ-026 Store data replicated: B = {4{wdata[7:0]}}; H = {2{wdata[15:0]}}; W = wdata.
REQ-027 Legal load: IDLE -> LOAD_REQ (o_read_req=1) -> LOAD_DATA (sample i_read_data, o_done=1, o_rdata valid) -> IDLE; latency 2 cycles.
REQ-028 Load extract: byte lane addr[1:0] or half lane addr[1]; B/H sign-extend, BU/HU zero-extend, W unchanged.
REQ-029 o_rdata SHALL hold its last load value until the next load completes; it is 0 after reset.
REQ-030 o_read_req, o_write_enable, o_done, o_error SHALL never be 1 in the same cycle as each other, except o_write_enable with o_done.
REQ-031 If clk_en falls mid-operation, the state and all strobes hold; the operation resumes when clk_en returns, and each strobe is counted once per enabled edge.
REQ-032 Back-to-back: a new operation MAY be accepted on the edge that returns the FSM to IDLE only on the following cycle; throughput is one op per 2 (store) or 3 (load) cycles.

Reset
REQ-033 rst=0 SHALL asynchronously force IDLE and drive o_done, o_error, o_read_req, o_write_enable to 0, o_byte_enable to 0000, and o_rdata, o_read_addr, o_write_addr, o_write_data to 0.
REQ-034 Reset asserted mid-operation aborts it with no RAM strobe and no o_done or o_error; o_ready=1 on the first edge after release.

Verification
REQ-035 SW addr 0x104, wdata 0xDEADBEEF -> next cycle o_write_enable=1, o_write_addr=0x41, o_byte_enable=1111, o_write_data=0xDEADBEEF, o_done=1.
REQ-036 SB addr 0x103, wdata 0x000000A5 -> o_byte_enable=1000, o_write_data=0xA5A5A5A5; follow-up LW 0x100 returns 0xA5xxxxxx.
REQ-037 RAM word 0x80FF7F01 at word 0x10: LB 0x41 -> 0x0000007F; LB 0x42 -> 0xFFFFFFFF; LBU 0x43 -> 0x00000080; LH 0x42 -> 0xFFFF80FF; LHU 0x40 -> 0x00007F01.
REQ-038 LW addr 0x102 and SH addr 0x101 -> o_error pulse one cycle after accept, no read/write strobe, o_ready=1 the cycle after.
REQ-039 LW with clk_en held 0 for 3 cycles in LOAD_REQ -> single o_read_req sample, o_done exactly once, correct data.
REQ-040 rst=0 during LOAD_REQ -> all outputs 0 immediately, no o_done; after release, LW completes normally.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one RV32I memory operation at a time from the core,
// checks alignment/legality, drives a single-word RAM data port, and returns
// sign- or zero-extended load results.
module load_store_unit #(
    parameter int ADDR_WIDTH = 31,
    parameter int DATA_WIDTH = 31
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clk_en,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic                  i_store,
    input  logic [2:0]            i_funct3,
    input  logic [ADDR_WIDTH:0]   i_addr,
    input  logic [DATA_WIDTH:0]   i_wdata,
    output logic                  o_done,
    output logic [DATA_WIDTH:0]   o_rdata,
    output logic                  o_error,
    output logic                  o_read_req,
    output logic [ADDR_WIDTH:0]   o_read_addr,
    input  logic [DATA_WIDTH:0]   i_read_data,
    output logic                  o_write_enable,
    output logic [3:0]            o_byte_enable,
    output logic [ADDR_WIDTH:0]   o_write_addr,
    output logic [DATA_WIDTH:0]   o_write_data
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        STORE     = 3'd1,
        LOAD_REQ  = 3'd2,
        LOAD_DATA = 3'd3,
        ERR       = 3'd4
    } state_t;

    state_t                state_reg;
    state_t                state_next;
    logic                  store_reg;
    logic [2:0]            funct3_reg;
    logic [ADDR_WIDTH:0]   addr_reg;
    logic [DATA_WIDTH:0]   wdata_reg;
    logic [DATA_WIDTH:0]   rdata_reg;
    logic                  accept;
    logic                  reject;
    logic [7:0]            byte_sel;
    logic [15:0]           half_sel;
    logic [DATA_WIDTH:0]   load_value;

    assign o_ready = (state_reg == IDLE);
    assign accept  = i_valid & o_ready;

    // Word address shared by both RAM ports comes from the captured byte address.
    assign o_read_addr  = {2'b00, addr_reg[ADDR_WIDTH:2]};
    assign o_write_addr = {2'b00, addr_reg[ADDR_WIDTH:2]};

    // Classify the presented operation: misaligned access or unsupported funct3.
    always_comb begin
        reject = 1'b0;
        case (i_funct3)
            3'b000:  reject = 1'b0;
            3'b001:  reject = i_addr[0];
            3'b010:  reject = (i_addr[1:0] != 2'b00);
            3'b100:  reject = i_store;
            3'b101:  reject = i_store | i_addr[0];
            default: reject = 1'b1;
        endcase
    end

    // State register; everything freezes while clk_en is low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
        end else if (clk_en) begin
            state_reg <= state_next;
        end
    end

    // Capture the operation on accept so later input changes cannot disturb it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            store_reg  <= 1'b0;
            funct3_reg <= 3'b000;
            addr_reg   <= '0;
            wdata_reg  <= '0;
        end else if (clk_en && accept) begin
            store_reg  <= i_store;
            funct3_reg <= i_funct3;
            addr_reg   <= i_addr;
            wdata_reg  <= i_wdata;
        end
    end

    // Next-state and strobe decode; strobes are pure functions of the state.
    always_comb begin
        state_next     = state_reg;
        o_done         = 1'b0;
        o_error        = 1'b0;
        o_read_req     = 1'b0;
        o_write_enable = 1'b0;
        case (state_reg)
            IDLE: begin
                if (i_valid) begin
                    if (reject)       state_next = ERR;
                    else if (i_store) state_next = STORE;
                    else              state_next = LOAD_REQ;
                end
            end
            STORE: begin
                o_write_enable = 1'b1;
                o_done         = 1'b1;
                state_next     = IDLE;
            end
            LOAD_REQ: begin
                o_read_req = 1'b1;
                state_next = LOAD_DATA;
            end
            LOAD_DATA: begin
                o_done     = 1'b1;
                state_next = IDLE;
            end
            ERR: begin
                o_error    = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Per-lane byte enables and replicated store data.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            localparam logic [1:0] LANE = 2'(gi);
            assign o_byte_enable[gi] = (state_reg == STORE) &&
                ((funct3_reg[1:0] == 2'b10) ||
                 ((funct3_reg[1:0] == 2'b01) && (LANE[1] == addr_reg[1])) ||
                 ((funct3_reg[1:0] == 2'b00) && (LANE == addr_reg[1:0])));
            assign o_write_data[8*gi +: 8] =
                (funct3_reg[1:0] == 2'b10) ? wdata_reg[8*gi +: 8] :
                (funct3_reg[1:0] == 2'b01) ? wdata_reg[8*(gi%2) +: 8] :
                                             wdata_reg[7:0];
        end
    endgenerate

    // Select the addressed lane of the RAM word and extend it to 32 bits.
    always_comb begin
        byte_sel   = i_read_data[7:0];
        half_sel   = addr_reg[1] ? i_read_data[31:16] : i_read_data[15:0];
        load_value = i_read_data;
        case (addr_reg[1:0])
            2'd0:    byte_sel = i_read_data[7:0];
            2'd1:    byte_sel = i_read_data[15:8];
            2'd2:    byte_sel = i_read_data[23:16];
            default: byte_sel = i_read_data[31:24];
        endcase
        case (funct3_reg)
            3'b000:  load_value = {{24{byte_sel[7]}}, byte_sel};
            3'b001:  load_value = {{16{half_sel[15]}}, half_sel};
            3'b100:  load_value = {24'd0, byte_sel};
            3'b101:  load_value = {16'd0, half_sel};
            default: load_value = i_read_data;
        endcase
    end

    // Keep the last completed load result for the core.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata_reg <= '0;
        end else if (clk_en && state_reg == LOAD_DATA) begin
            rdata_reg <= load_value;
        end
    end

    // During the retire cycle the fresh value is presented directly.
    assign o_rdata = (state_reg == LOAD_DATA) ? load_value : rdata_reg;

endmodule
